mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 106 ++++++++++
 tb/tb_mult_share_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Purpose: two requesters share one 4x4 unsigned multiplier. A fair round-robin picks the winner when both requesters want it in the same cycle.
// Latency: accept at cycle t, multiply at t+1, response valid from t+2. Each operation occupies the unit for at least 3 cycles.
// Backpressure: a product is held in HOLD for as long as needed. No new request is accepted until the response handshake completes.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   reqN_valid/_a/_b/_ready      operand handshake for requester N (N = 0, 1)
//   rspN_valid/_ready/_prod      product handshake for requester N
//   busy                         unit is not idle
//   done_cnt                     wrapping count of completed responses
module mult_share_arbiter #(
    parameter int RR_START = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_prod,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_prod,
    output logic       busy,
    output logic [7:0] done_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0] state;
    logic       prio;      // requester that wins a tie
    logic       owner;     // requester whose operation is in flight
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [7:0] prod_r;
    logic       grant0;
    logic       grant1;
    logic       rsp_done;

    // A lone requester always wins. On a tie the priority holder wins.
    // The two grants are mutually exclusive by construction.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~prio);
        grant1 = req1_valid & (~req0_valid |  prio);
    end

    // Every outward handshake signal is masked by rst, so a reset cycle cannot complete a transfer.
    assign req0_ready = ~rst & (state == IDLE) & grant0;
    assign req1_ready = ~rst & (state == IDLE) & grant1;
    assign rsp0_valid = ~rst & (state == HOLD) & ~owner;
    assign rsp1_valid = ~rst & (state == HOLD) &  owner;
    assign rsp0_prod  = prod_r;
    assign rsp1_prod  = prod_r;
    assign busy       = ~rst & (state != IDLE);
    assign rsp_done   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= (RR_START != 0);
            owner    <= 1'b0;
            a_r      <= 4'd0;
            b_r      <= 4'd0;
            prod_r   <= 8'd0;
            done_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid & req0_ready) begin
                        a_r   <= req0_a;
                        b_r   <= req0_b;
                        owner <= 1'b0;
                        state <= MUL;
                    end else if (req1_valid & req1_ready) begin
                        a_r   <= req1_a;
                        b_r   <= req1_b;
                        owner <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    // 15*15 = 225, so the full product fits in 8 bits.
                    prod_r <= {4'd0, a_r} * {4'd0, b_r};
                    state  <= HOLD;
                end
                HOLD: begin
                    if (rsp_done) begin
                        state    <= IDLE;
                        prio     <= ~owner;
                        done_cnt <= done_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_prod, rsp1_prod;
    logic       busy;
    logic [7:0] done_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state: tie-break owner and completed-operation count
    int exp_prio = 0;
    int exp_done = 0;

    mult_share_arbiter #(.RR_START(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_prod(rsp0_prod),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_prod(rsp1_prod),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_prio = 0;
        exp_done = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick(); tick();
        req0_valid = 1'b1;
        #1;
        total_cnt++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0 got=%b want=0", req0_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy); else pass_cnt++;
        total_cnt++; if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL rst_rspv got=%b want=00", {rsp0_valid, rsp1_valid}); else pass_cnt++;
        total_cnt++; if (done_cnt !== 8'd0) $display("FAIL rst_done got=%0d want=0", done_cnt); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (req0_ready !== 1'b1) $display("FAIL rst_release_ready got=%b want=1", req0_ready); else pass_cnt++;
        req0_valid = 1'b0;
        exp_prio = 0; exp_done = 0;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
        #1;
        total_cnt++; if (req0_ready !== 1'b1) $display("FAIL single_ready got=%b want=1", req0_ready); else pass_cnt++;
        tick();                       // accept edge
        req0_valid = 1'b0; req0_a = 4'd2; req0_b = 4'd3;   // changes after acceptance must be ignored
        #1;
        total_cnt++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) $display("FAIL single_mul busy=%b rspv=%b want busy=1 rspv=0", busy, rsp0_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rsp0_valid !== 1'b1 || rsp0_prod !== 8'hE1 || rsp1_valid !== 1'b0)
            $display("FAIL single_hold rspv=%b prod=%h rsp1v=%b want 1 e1 0", rsp0_valid, rsp0_prod, rsp1_valid); else pass_cnt++;
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        exp_done++; exp_prio = 1;
        total_cnt++; if (done_cnt !== 8'(exp_done) || busy !== 1'b0) $display("FAIL single_done cnt=%0d busy=%b want %0d 0", done_cnt, busy, exp_done); else pass_cnt++;
    endtask

    task automatic test_contention();
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd9;
        #1;
        total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL cont_tie1 got=%b want=10", {req0_ready, req1_ready}); else pass_cnt++;
        tick();
        total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL cont_mul_rdy got=%b want=00", {req0_ready, req1_ready}); else pass_cnt++;
        tick();
        total_cnt++; if (rsp0_valid !== 1'b1 || rsp0_prod !== 8'd15 || req1_ready !== 1'b0)
            $display("FAIL cont_rsp0 v=%b prod=%0d r1=%b want 1 15 0", rsp0_valid, rsp0_prod, req1_ready); else pass_cnt++;
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        total_cnt++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL cont_tie2 got=%b want=01", {req0_ready, req1_ready}); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (rsp1_valid !== 1'b1 || rsp1_prod !== 8'd63 || rsp0_valid !== 1'b0)
            $display("FAIL cont_rsp1 v=%b prod=%0d rsp0v=%b want 1 63 0", rsp1_valid, rsp1_prod, rsp0_valid); else pass_cnt++;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        #1;
        total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL cont_tie3 got=%b want=10", {req0_ready, req1_ready}); else pass_cnt++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_done = 2; exp_prio = 0;
        total_cnt++; if (done_cnt !== 8'd2) $display("FAIL cont_done got=%0d want=2", done_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd6;
        tick();
        req0_valid = 1'b0;
        tick();
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;   // arrives while busy and must wait
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (rsp0_valid !== 1'b1 || rsp0_prod !== 8'd24 || busy !== 1'b1 || {req0_ready, req1_ready} !== 2'b00)
                $display("FAIL bp_hold%0d v=%b prod=%0d busy=%b rdy=%b want 1 24 1 00", i, rsp0_valid, rsp0_prod, busy, {req0_ready, req1_ready});
            else pass_cnt++;
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        exp_done++; exp_prio = 1;
        #1;
        total_cnt++; if (busy !== 1'b0 || done_cnt !== 8'(exp_done)) $display("FAIL bp_done busy=%b cnt=%0d want 0 %0d", busy, done_cnt, exp_done); else pass_cnt++;
        total_cnt++; if (req1_ready !== 1'b1) $display("FAIL bp_waiter got=%b want=1", req1_ready); else pass_cnt++;
        req1_valid = 1'b0;            // withdrawn without a handshake
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL bp_withdraw busy=%b want=0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5;
        tick();                       // accepted, now in MUL
        req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy_in_rst got=%b want=0", busy); else pass_cnt++;
        tick();
        rst = 1'b0;
        exp_done = 0; exp_prio = 0;
        #1;
        total_cnt++; if (busy !== 1'b0 || {rsp0_valid, rsp1_valid} !== 2'b00 || done_cnt !== 8'd0)
            $display("FAIL rmid_after busy=%b rspv=%b cnt=%0d want 0 00 0", busy, {rsp0_valid, rsp1_valid}, done_cnt); else pass_cnt++;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (rsp1_valid !== 1'b0 || done_cnt !== 8'd0) $display("FAIL rmid_no_rsp%0d v=%b cnt=%0d want 0 0", i, rsp1_valid, done_cnt); else pass_cnt++;
        end
        rsp1_ready = 1'b0;
    endtask

    // 256 randomized operations checked against the arbitration rules, then the counter wrap.
    task automatic test_back_to_back();
        int   g, ia, ib, hold;
        logic v0, v1;
        logic [3:0] a0, b0, a1, b1;
        logic [7:0] exp_p;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
            a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
            v0 = 1'($urandom_range(0, 1));  v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            if (n == 0) begin v0 = 1'b1; v1 = 1'b0; a0 = 4'd0; b0 = 4'd9; end
            g = (v0 && v1) ? exp_prio : (v0 ? 0 : 1);
            ia = (g == 0) ? int'(a0) : int'(a1);
            ib = (g == 0) ? int'(b0) : int'(b1);
            exp_p = 8'(ia * ib);
            req0_valid = v0; req0_a = a0; req0_b = b0;
            req1_valid = v1; req1_a = a1; req1_b = b1;
            #1;
            total_cnt++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1))
                $display("FAIL b2b_grant n=%0d rdy=%b%b want grant %0d", n, req0_ready, req1_ready, g); else pass_cnt++;
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_a = ~a0; req1_b = ~b1;
            hold = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if (hold != 0) begin rsp0_ready = 1'b0; rsp1_ready = 1'b0; end
            tick();
            if (hold != 0) tick();
            total_cnt++; if ((g == 0 ? rsp0_valid : rsp1_valid) !== 1'b1 || (g == 0 ? rsp1_valid : rsp0_valid) !== 1'b0 ||
                             (g == 0 ? rsp0_prod : rsp1_prod) !== exp_p)
                $display("FAIL b2b_rsp n=%0d v=%b%b prod=%0d want owner %0d prod %0d", n, rsp0_valid, rsp1_valid,
                         (g == 0 ? rsp0_prod : rsp1_prod), g, exp_p); else pass_cnt++;
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            tick();
            exp_done = (exp_done + 1) % 256;
            exp_prio = 1 - g;
            if (n == 254) begin
                total_cnt++; if (done_cnt !== 8'd255) $display("FAIL b2b_cnt255 got=%0d want=255", done_cnt); else pass_cnt++;
            end
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        total_cnt++; if (done_cnt !== 8'(exp_done)) $display("FAIL b2b_wrap got=%0d want=%0d", done_cnt, exp_done); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
